// File: rtl/controle_turno.sv
// Turn sequencer for the two-player naval game: takes a shot, reads the opponent's
// board word, clears a hit cell, runs the piece counter and decides winner/turn.
module controle_turno #(
    parameter int ADDR_W      = 5,
    parameter int ULTIMO_ADDR = 11,
    parameter int CEL_LSB     = 3,
    parameter int CEL_MSB     = 42
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              tiro_valido,
    input  logic [ADDR_W-1:0] tiro_addr,
    input  logic [5:0]        tiro_bit,
    output logic              tiro_aceito,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [63:0]       mem_rdata,
    output logic              mem_we,
    output logic [63:0]       mem_wdata,
    output logic              cont_enable,
    input  logic              cont_ready,
    input  logic [3:0]        qtd_P1,
    input  logic [3:0]        qtd_P2,
    output logic              jogador,
    output logic              acertou,
    output logic              fim_jogo,
    output logic              vencedor
);

    typedef enum logic [2:0] {
        OCIOSO, ESPERA_TIRO, LE, VERIFICA, ESCREVE, CONTA, DECIDE, FIM
    } estado_t;

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [5:0]        bit_q, bit_d;
    logic [63:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              cont_q, cont_d;
    logic              aceito_q, aceito_d;
    logic              jog_q, jog_d;
    logic              acertou_q, acertou_d;
    logic              fim_q, fim_d;
    logic              venc_q, venc_d;

    logic              tiro_ok;
    logic [3:0]        qtd_oponente;

    assign tiro_ok = (tiro_addr <= ADDR_W'(ULTIMO_ADDR)) &&
                     (tiro_bit >= 6'(CEL_LSB)) && (tiro_bit <= 6'(CEL_MSB));
    assign qtd_oponente = jog_q ? qtd_P1 : qtd_P2;

    always_comb begin
        estado_d  = estado_q;
        addr_d    = addr_q;
        bit_d     = bit_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        cont_d    = cont_q;
        aceito_d  = 1'b0;
        jog_d     = jog_q;
        acertou_d = acertou_q;
        fim_d     = fim_q;
        venc_d    = venc_q;
        case (estado_q)
            OCIOSO: begin
                if (start) begin
                    jog_d    = 1'b0;
                    estado_d = ESPERA_TIRO;
                end
            end
            ESPERA_TIRO: begin
                if (tiro_valido && tiro_ok) begin
                    addr_d   = tiro_addr;
                    bit_d    = tiro_bit;
                    aceito_d = 1'b1;
                    estado_d = LE;
                end
            end
            LE: estado_d = VERIFICA;
            VERIFICA: begin
                // A cell already cleared reads as 0, so a re-fire is just a miss
                if (mem_rdata[bit_q]) begin
                    acertou_d = 1'b1;
                    wdata_d   = mem_rdata & ~(64'd1 << bit_q);
                    we_d      = 1'b1;
                    estado_d  = ESCREVE;
                end else begin
                    acertou_d = 1'b0;
                    cont_d    = 1'b1;
                    estado_d  = CONTA;
                end
            end
            ESCREVE: begin
                cont_d   = 1'b1;
                estado_d = CONTA;
            end
            CONTA: begin
                // Dropping enable here guarantees a low cycle (DECIDE) before the next scan
                if (cont_ready) begin
                    cont_d   = 1'b0;
                    estado_d = DECIDE;
                end
            end
            DECIDE: begin
                if (qtd_oponente == 4'd0) begin
                    fim_d    = 1'b1;
                    venc_d   = jog_q;
                    estado_d = FIM;
                end else begin
                    if (!acertou_q) jog_d = ~jog_q;
                    estado_d = ESPERA_TIRO;
                end
            end
            FIM: begin
                if (start) begin
                    fim_d    = 1'b0;
                    jog_d    = 1'b0;
                    estado_d = ESPERA_TIRO;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            addr_q    <= '0;
            bit_q     <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            cont_q    <= 1'b0;
            aceito_q  <= 1'b0;
            jog_q     <= 1'b0;
            acertou_q <= 1'b0;
            fim_q     <= 1'b0;
            venc_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            addr_q    <= addr_d;
            bit_q     <= bit_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            cont_q    <= cont_d;
            aceito_q  <= aceito_d;
            jog_q     <= jog_d;
            acertou_q <= acertou_d;
            fim_q     <= fim_d;
            venc_q    <= venc_d;
        end
    end

    assign tiro_aceito = aceito_q;
    assign mem_sel     = ~jog_q;
    assign mem_addr    = addr_q;
    assign mem_we      = we_q;
    assign mem_wdata   = wdata_q;
    assign cont_enable = cont_q;
    assign jogador     = jog_q;
    assign acertou     = acertou_q;
    assign fim_jogo    = fim_q;
    assign vencedor    = venc_q;

endmodule

// File: tb/tb_controle_turno.sv
// Bench for controle_turno: board memories and piece counter modelled here, directed
// table plus random shots checked against a set-of-cells game model.
module tb_controle_turno;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        tiro_valido = 1'b0;
    logic [4:0]  tiro_addr = '0;
    logic [5:0]  tiro_bit = '0;
    logic        tiro_aceito, mem_sel, mem_we, cont_enable, cont_ready;
    logic [4:0]  mem_addr;
    logic [63:0] mem_rdata = '0;
    logic [63:0] mem_wdata;
    logic [3:0]  qtd_P1 = '0, qtd_P2 = '0;
    logic        jogador, acertou, fim_jogo, vencedor;

    controle_turno dut (
        .clk(clk), .reset(reset), .start(start), .tiro_valido(tiro_valido),
        .tiro_addr(tiro_addr), .tiro_bit(tiro_bit), .tiro_aceito(tiro_aceito),
        .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .cont_enable(cont_enable),
        .cont_ready(cont_ready), .qtd_P1(qtd_P1), .qtd_P2(qtd_P2),
        .jogador(jogador), .acertou(acertou), .fim_jogo(fim_jogo), .vencedor(vencedor)
    );

    always #5 clk = ~clk;

    // Board memories (index 0 = P1, 1 = P2), image to load, and the game model
    logic [63:0] mem [2][32];
    logic [63:0] img [2][32];
    logic [63:0] mdl [2][32];
    logic        load = 1'b0;
    int          we_cnt = 0;
    int          ccnt = 0;
    int          rdy_dly = 0;
    int          nvec = 0, nerr = 0;
    logic        m_run, m_jog, m_acert, m_fim, m_venc;

    function automatic int cells(input logic [63:0] w);
        int n = 0;
        for (int i = 3; i <= 42; i++) n += int'(w[i]);
        return n;
    endfunction

    always @(posedge clk) begin
        if (load) begin
            for (int b = 0; b < 2; b++)
                for (int w = 0; w < 32; w++) mem[b][w] <= img[b][w];
        end else if (mem_we) begin
            mem[mem_sel][mem_addr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        mem_rdata <= mem[mem_sel][mem_addr];
        ccnt <= cont_enable ? ccnt + 1 : 0;
    end

    assign cont_ready = cont_enable && (ccnt >= rdy_dly);

    // Piece counter stand-in: remaining cells on each board, saturated to 4 bits
    always @(negedge clk) begin
        int s0, s1;
        s0 = 0; s1 = 0;
        for (int w = 0; w < 12; w++) begin
            s0 += cells(mem[0][w]);
            s1 += cells(mem[1][w]);
        end
        qtd_P1 = (s0 > 15) ? 4'd15 : 4'(s0);
        qtd_P2 = (s1 > 15) ? 4'd15 : 4'(s1);
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load_boards();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int w = 0; w < 32; w++) mdl[b][w] = img[b][w];
    endtask

    task automatic directed_boards();
        for (int b = 0; b < 2; b++)
            for (int w = 0; w < 32; w++) img[b][w] = '0;
        img[0][0] = 64'h0000_0000_0000_0009;
        img[0][5] = 64'h0000_0000_0000_0400;
        img[1][2] = 64'hA5A0_0000_0000_0027;
        img[1][7] = 64'h0000_0000_0010_0000;
        load_boards();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_jogador"}, 64'(jogador), 0);
        chk({tag, "_acertou"}, 64'(acertou), 0);
        chk({tag, "_fim"}, 64'(fim_jogo), 0);
        chk({tag, "_vencedor"}, 64'(vencedor), 0);
        chk({tag, "_mem_we"}, 64'(mem_we), 0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_cont_en"}, 64'(cont_enable), 0);
        chk({tag, "_aceito"}, 64'(tiro_aceito), 0);
        chk({tag, "_mem_sel"}, 64'(mem_sel), 1);
    endtask

    task automatic model_reset();
        m_run = 0; m_jog = 0; m_acert = 0; m_fim = 0; m_venc = 0;
    endtask

    task automatic do_reset(input logic with_start);
        reset = 1'b1;
        start = with_start;
        @(negedge clk);
        start = 1'b0;
        model_reset();
        chk_reset_vals("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (!m_run || m_fim) begin
            m_run = 1; m_fim = 0; m_jog = 0;
        end
        chk("start_jogador", 64'(jogador), 64'(m_jog));
        chk("start_fim", 64'(fim_jogo), 64'(m_fim));
    endtask

    task automatic shot(input int a, input int b, input int dly, output logic acc);
        logic exp_acc, hit, bad;
        int   we0, n, opp, cnt;
        exp_acc = m_run && !m_fim && a <= 11 && b >= 3 && b <= 42;
        rdy_dly = dly;
        we0 = we_cnt;
        tiro_addr = 5'(a);
        tiro_bit = 6'(b);
        tiro_valido = 1'b1;
        @(negedge clk);
        tiro_valido = 1'b0;
        acc = tiro_aceito;
        chk("tiro_aceito", 64'(tiro_aceito), 64'(exp_acc));
        if (exp_acc) begin
            opp = m_jog ? 0 : 1;
            chk("mem_sel_shot", 64'(mem_sel), 64'(opp));
            chk("mem_addr_shot", 64'(mem_addr), 64'(a));
            hit = mdl[opp][a][b];
            mdl[opp][a][b] = 1'b0;
            @(negedge clk);
            chk("aceito_one_cycle", 64'(tiro_aceito), 0);
            n = 0;
            while (!cont_enable && n < 10) begin @(negedge clk); n++; end
            chk("cont_enable_rise", 64'(cont_enable), 1);
            n = 0;
            while (cont_enable && n < 300) begin @(negedge clk); n++; end
            chk("cont_enable_cycles", 64'(n), 64'(dly + 1));
            chk("mem_we_count", 64'(we_cnt - we0), 64'(hit));
            @(negedge clk);
            cnt = 0;
            for (int w = 0; w < 12; w++) cnt += cells(mdl[opp][w]);
            m_acert = hit;
            if (cnt == 0) begin
                m_fim = 1; m_venc = m_jog;
            end else if (!hit) begin
                m_jog = !m_jog;
            end
            chk("acertou", 64'(acertou), 64'(m_acert));
            chk("jogador", 64'(jogador), 64'(m_jog));
            chk("fim_jogo", 64'(fim_jogo), 64'(m_fim));
            if (m_fim) chk("vencedor", 64'(vencedor), 64'(m_venc));
            chk("mem_sel_after", 64'(mem_sel), 64'(!m_jog));
            chk("cont_enable_gap", 64'(cont_enable), 0);
            chk("board_word", mem[opp][a], mdl[opp][a]);
        end else begin
            bad = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (tiro_aceito || cont_enable || mem_we) bad = 1'b1;
            end
            chk("ignored_quiet", 64'(bad), 0);
            chk("ignored_jogador", 64'(jogador), 64'(m_jog));
            chk("ignored_fim", 64'(fim_jogo), 64'(m_fim));
        end
    endtask

    typedef struct {
        int   a;
        int   b;
        logic acc;
        logic hit;
        logic jog;
    } vec_t;
    vec_t tbl[9];

    initial begin
        logic acc;
        int   n;
        int   ta[$];
        int   tb_[$];
        tbl[0] = '{2, 5, 1, 1, 0};
        tbl[1] = '{2, 5, 1, 0, 1};
        tbl[2] = '{12, 5, 0, 0, 1};
        tbl[3] = '{3, 2, 0, 0, 1};
        tbl[4] = '{3, 43, 0, 0, 1};
        tbl[5] = '{0, 3, 1, 1, 1};
        tbl[6] = '{11, 42, 1, 0, 0};
        tbl[7] = '{7, 20, 1, 1, 0};
        tbl[8] = '{4, 10, 0, 1, 0};

        model_reset();
        directed_boards();
        do_reset(1'b1);
        shot(2, 5, 0, acc);
        do_start();

        for (int i = 0; i < 9; i++) begin
            shot(tbl[i].a, tbl[i].b, i % 2, acc);
            chk($sformatf("tbl%0d_acc", i), 64'(acc), 64'(tbl[i].acc));
            chk($sformatf("tbl%0d_hit", i), 64'(acertou), 64'(tbl[i].hit));
            chk($sformatf("tbl%0d_jog", i), 64'(jogador), 64'(tbl[i].jog));
            if (i == 0) chk("tbl0_word", mem[1][2], 64'hA5A0_0000_0000_0007);
        end
        chk("final_fim", 64'(fim_jogo), 1);
        chk("final_vencedor", 64'(vencedor), 0);
        do_start();
        chk("restart_fim", 64'(fim_jogo), 0);
        chk("restart_jog", 64'(jogador), 0);

        directed_boards();
        shot(1, 4, 20, acc);
        chk("slow_count_jog", 64'(jogador), 1);

        // Reset while the counter is still running
        rdy_dly = 20;
        tiro_addr = 5'd1; tiro_bit = 6'd4; tiro_valido = 1'b1;
        @(negedge clk);
        tiro_valido = 1'b0;
        n = 0;
        while (!cont_enable && n < 10) begin @(negedge clk); n++; end
        chk("conta_reached", 64'(cont_enable), 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_conta");
        reset = 1'b0;
        model_reset();

        // Reset while the write strobe is up
        directed_boards();
        do_start();
        rdy_dly = 0;
        tiro_addr = 5'd2; tiro_bit = 6'd5; tiro_valido = 1'b1;
        @(negedge clk);
        tiro_valido = 1'b0;
        n = 0;
        while (!mem_we && n < 10) begin @(negedge clk); n++; end
        chk("escreve_reached", 64'(mem_we), 1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_escreve");
        reset = 1'b0;
        model_reset();

        // Random games against the model
        for (int g = 0; g < 200; g++) begin
            if (!m_run || m_fim) begin
                ta.delete(); tb_.delete();
                for (int b = 0; b < 2; b++)
                    for (int w = 0; w < 32; w++)
                        img[b][w] = {$urandom, $urandom} & ~64'h0000_07FF_FFFF_FFF8;
                for (int b = 0; b < 2; b++)
                    for (int k = 0; k < 3; k++) begin
                        int wa, wb;
                        wa = int'($urandom_range(0, 11));
                        wb = int'($urandom_range(3, 42));
                        img[b][wa][wb] = 1'b1;
                        ta.push_back(wa); tb_.push_back(wb);
                    end
                load_boards();
                do_start();
            end
            if ($urandom_range(0, 9) == 0) begin
                do_start();
            end else if ($urandom_range(0, 1) == 0) begin
                n = int'($urandom_range(0, ta.size() - 1));
                shot(ta[n], tb_[n], int'($urandom_range(0, 4)), acc);
            end else begin
                shot(int'($urandom_range(0, 14)), int'($urandom_range(0, 47)),
                     int'($urandom_range(0, 4)), acc);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
